// File: rtl/multicycle_muldiv.sv
// multicycle_muldiv
//   Iterative multiply/divide unit with HI/LO result registers. It produces
//   one result bit per clock, with no combinational multiplier. Magnitudes
//   are computed in CALC, and the sign is applied in a single FIX cycle.
//
// Ports
//   i_clk, i_rst       clock and synchronous active-high reset
//   i_start, i_op      start request and operation (00 MULT, 01 MULTU,
//                      10 DIV, 11 DIVU); sampled only in IDLE
//   i_a, i_b           operands (multiplicand/dividend, multiplier/divisor)
//   i_hi_we, i_lo_we   MTHI / MTLO write enables, used with i_wdata
//   o_busy             high in every state other than IDLE
//   o_done             one-cycle pulse; HI/LO already hold the new result
//   o_hi, o_lo         HI (product upper half / remainder) and
//                      LO (product lower half / quotient)
//   o_div_zero         qualified by o_done; the divisor was zero
//
// Handshake: a request is taken in the cycle where i_start=1 and o_busy=0.
// From that point o_busy stays high until o_done has pulsed. A start seen
// while busy is dropped, not queued.
module multicycle_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // The accumulator is shared. For a multiply it holds {partial product,
  // multiplier}. For a divide it holds {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Magnitude of the multiplicand (multiply) or of the divisor (divide).
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;       // product / quotient sign
  logic               rem_neg_q, rem_neg_d; // remainder follows dividend
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;

  // Operand conditioning at capture time
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign signed_op = ~i_op[0];
  assign a_neg     = signed_op & i_a[WIDTH-1];
  assign b_neg     = signed_op & i_b[WIDTH-1];
  assign a_abs     = a_neg ? (~i_a + 1'b1) : i_a;
  assign b_abs     = b_neg ? (~i_b + 1'b1) : i_b;

  // Per-iteration datapath
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_trial;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  // The shifted partial remainder minus the divisor. The MSB set means the
  // result is negative, so the restoring step keeps the old remainder.
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

  // Sign correction terms used in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_mag, rem_mag;

  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_mag  = acc_q[WIDTH-1:0];
  assign rem_mag  = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          // A start takes priority over MTHI/MTLO in the same cycle.
          is_div_d  = i_op[1];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          cnt_d     = '0;
          if (i_op[1] && (i_b == '0)) begin
            hi_d       = i_a;
            lo_d       = '1;
            div_zero_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            div_zero_d = 1'b0;
            state_d    = S_CALC;
            if (i_op[1]) begin
              acc_d  = {{WIDTH{1'b0}}, a_abs};
              opnd_d = b_abs;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_abs};
              opnd_d = a_abs;
            end
          end
        end else begin
          if (i_hi_we) hi_d = i_wdata;
          if (i_lo_we) lo_d = i_wdata;
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          if (!div_trial[WIDTH])
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          // Add the multiplicand if the multiplier LSB is set, then shift right.
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          // The quotient truncates toward zero. The remainder takes the sign
          // of the dividend. Most-negative / -1 wraps back to most-negative.
          lo_d = neg_q ? (~quo_mag + 1'b1) : quo_mag;
          hi_d = rem_neg_q ? (~rem_mag + 1'b1) : rem_mag;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        div_zero_d = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_DONE);
  assign o_hi       = hi_q;
  assign o_lo       = lo_q;
  assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_multicycle_muldiv.sv
// Directed testbench for multicycle_muldiv (WIDTH=32).
module tb_multicycle_muldiv;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         hi_we, lo_we;
  logic [W-1:0] wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  multicycle_muldiv #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_op       (op),
    .i_a        (a),
    .i_b        (b),
    .i_hi_we    (hi_we),
    .i_lo_we    (lo_we),
    .i_wdata    (wdata),
    .o_busy     (busy),
    .o_done     (done),
    .o_hi       (hi),
    .o_lo       (lo),
    .o_div_zero (div_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drives one operation starting in "cycle 0" and waits for o_done.
  // The task checks latency, that o_busy is high on every cycle up to
  // done, and that HI/LO do not move before done. The operands are
  // scrambled after capture. poke: mid-CALC start + MTHI attempt.
  // lo_poke: MTLO asserted together with start.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] va, input logic [W-1:0] vb,
                        input int exp_lat, input bit poke, input bit lo_poke);
    logic [W-1:0] hi0, lo0;
    int n, busy_bad, move_bad;
    hi0 = hi;
    lo0 = lo;
    op = o; a = va; b = vb; start = 1'b1;
    if (lo_poke) begin lo_we = 1'b1; wdata = 32'h0000_0055; end
    tick();
    start = 1'b0; lo_we = 1'b0;
    op = 2'($urandom_range(0, 3));
    a  = $urandom; b = $urandom; wdata = $urandom;
    n = 1; busy_bad = 0; move_bad = 0;
    while (!done && n < 100) begin
      if (!busy) busy_bad++;
      if (hi !== hi0 || lo !== lo0) move_bad++;
      if (poke && n == 5) begin
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      tick();
      start = 1'b0; hi_we = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    chk({tag, "_hilo_stable"}, 64'(move_bad), 64'd0);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
  endtask

  task automatic after_done(input string tag);
    tick();
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_done_after"}, 64'(done), 64'd0);
    chk({tag, "_dz_after"}, 64'(div_zero), 64'd0);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    rst = 1'b0;
    tick();

    // MULT -3 * 7 = -21
    run_op("mult", 2'b00, 32'hFFFF_FFFD, 32'd7, 34, 1'b0, 1'b0);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
    chk("mult_dz", 64'(div_zero), 64'd0);
    after_done("mult");

    // MULTU (2^32-1)^2
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0, 1'b0);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);
    after_done("multu");

    // DIV -7 / 2 -> q=-3, r=-1
    run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 34, 1'b0, 1'b0);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    after_done("div");

    // DIVU 100 / 7 -> q=14, r=2
    run_op("divu", 2'b11, 32'd100, 32'd7, 34, 1'b0, 1'b0);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
    after_done("divu");

    // DIV most-negative / -1
    run_op("divmin", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b0, 1'b0);
    chk("divmin_lo", 64'(lo), 64'h8000_0000);
    chk("divmin_hi", 64'(hi), 64'd0);
    after_done("divmin");

    // DIVU by zero: done in cycle 1
    run_op("divz", 2'b11, 32'h0000_1234, 32'd0, 1, 1'b0, 1'b0);
    chk("divz_dz", 64'(div_zero), 64'd1);
    chk("divz_hi", 64'(hi), 64'h0000_1234);
    chk("divz_lo", 64'(lo), 64'hFFFF_FFFF);
    after_done("divz");

    // MULTU 5*6 with an ignored restart and an ignored MTHI mid-CALC
    run_op("poke", 2'b01, 32'd5, 32'd6, 34, 1'b1, 1'b0);
    chk("poke_hi", 64'(hi), 64'd0);
    chk("poke_lo", 64'(lo), 64'd30);
    after_done("poke");

    // MTHI + MTLO in the same IDLE cycle
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    tick();
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    chk("mt_hi", 64'(hi), 64'hA5A5_A5A5);
    chk("mt_lo", 64'(lo), 64'hA5A5_A5A5);
    chk("mt_busy", 64'(busy), 64'd0);

    // MTHI only
    hi_we = 1'b1; wdata = 32'h0BAD_F00D;
    tick();
    hi_we = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h0BAD_F00D);
    chk("mthi_lo", 64'(lo), 64'hA5A5_A5A5);

    // start together with MTLO: the start wins (LO must not become 0x55)
    run_op("startwe", 2'b11, 32'd100, 32'd7, 34, 1'b0, 1'b1);
    chk("startwe_lo", 64'(lo), 64'd14);
    chk("startwe_hi", 64'(hi), 64'd2);
    after_done("startwe");

    // Reset in the middle of CALC
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) done_seen++;
      tick();
    end
    chk("midrst_no_done", 64'(done_seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
